// File: rtl/ee201l_detour_ctrl_if.sv
// Crew-side / sign-side signal bundle for the detour sign controller.
// DETOUR_CTRL_EMERG_EN adds the emerg request line.
interface ee201l_detour_ctrl_if;
    logic       req_l;
    logic       req_r;
`ifdef DETOUR_CTRL_EMERG_EN
    logic       emerg;
`endif
    logic       lr_bar;
    logic       tick;
    logic       sign_on;
    logic       sign_clr;
    logic       gnt_l;
    logic       gnt_r;
    logic [2:0] state;

`ifdef DETOUR_CTRL_EMERG_EN
    modport master (
        output req_l, req_r, emerg,
        input  lr_bar, tick, sign_on, sign_clr, gnt_l, gnt_r, state
    );
    modport slave (
        input  req_l, req_r, emerg,
        output lr_bar, tick, sign_on, sign_clr, gnt_l, gnt_r, state
    );
`else
    modport master (
        output req_l, req_r,
        input  lr_bar, tick, sign_on, sign_clr, gnt_l, gnt_r, state
    );
    modport slave (
        input  req_l, req_r,
        output lr_bar, tick, sign_on, sign_clr, gnt_l, gnt_r, state
    );
`endif
endinterface

// File: rtl/ee201l_detour_ctrl.sv
// Round-robin arbiter, tick prescaler and restart control for the ee201l_detour sign.
// Optional emergency hold is enabled by defining DETOUR_CTRL_EMERG_EN.
module ee201l_detour_ctrl #(
    parameter int DIV         = 4,
    parameter int SWEEP_STEPS = 4,
    parameter int MIN_SWEEPS  = 2
) (
    input logic                 clk,
    input logic                 reset_bar,
    ee201l_detour_ctrl_if.slave bus
);
    localparam int PW = $clog2(DIV);
    localparam int SW = $clog2(SWEEP_STEPS);
    localparam int CW = $clog2(MIN_SWEEPS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_PEN   = PW'(DIV - 2);
    localparam logic [SW-1:0] STEP_LAST = SW'(SWEEP_STEPS - 1);
    localparam logic [CW-1:0] SWEEP_MIN = CW'(MIN_SWEEPS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_L  = 3'd1,
        RUN_R  = 3'd2,
        SWITCH = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [SW-1:0] step;
    logic [CW-1:0] sweeps;
    logic          last_l;
    logic          lr_bar, tick, sign_on, sign_clr, gnt_l, gnt_r;

    logic emerg, running, enter, enter_l, own_req, other_req, eligible;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= SWEEP_MIN) ? SWEEP_MIN : v + CW'(1);
    endfunction

`ifdef DETOUR_CTRL_EMERG_EN
    assign emerg = bus.emerg;
`else
    assign emerg = 1'b0;
`endif

    // A tie in IDLE goes to the side that did not hold the sign last.
    assign running   = (state == RUN_L) || (state == RUN_R);
    assign enter     = ((state == IDLE) && (bus.req_l || bus.req_r)) || (state == SWITCH);
    assign enter_l   = (state == SWITCH) ? !last_l
                                         : (bus.req_l && (!bus.req_r || !last_l));
    assign own_req   = (state == RUN_L) ? bus.req_l : bus.req_r;
    assign other_req = (state == RUN_L) ? bus.req_r : bus.req_l;
    assign eligible  = (sat_inc(sweeps) >= SWEEP_MIN);

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state    <= IDLE;
            pre      <= '0;
            step     <= '0;
            sweeps   <= '0;
            last_l   <= 1'b0;
            lr_bar   <= 1'b0;
            tick     <= 1'b0;
            sign_on  <= 1'b0;
            sign_clr <= 1'b0;
            gnt_l    <= 1'b0;
            gnt_r    <= 1'b0;
        end else begin
            sign_clr <= 1'b0;
            tick     <= 1'b0;
            if (emerg) begin
                state    <= HOLD;
                sign_clr <= (state != HOLD);
                pre      <= '0;
                step     <= '0;
                sweeps   <= '0;
                sign_on  <= 1'b0;
                gnt_l    <= 1'b0;
                gnt_r    <= 1'b0;
            end else if (enter) begin
                state    <= enter_l ? RUN_L : RUN_R;
                lr_bar   <= enter_l;
                last_l   <= enter_l;
                sign_clr <= 1'b1;
                pre      <= '0;
                step     <= '0;
                sweeps   <= '0;
                sign_on  <= 1'b1;
                gnt_l    <= enter_l;
                gnt_r    <= !enter_l;
            end else if (running) begin
                // tick is registered one cycle ahead so it is high exactly while pre == DIV-1
                pre  <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
                tick <= (pre == PRE_PEN);
                if (tick) begin
                    if (step == STEP_LAST) begin
                        step   <= '0;
                        sweeps <= sat_inc(sweeps);
                        if (eligible && (other_req || !own_req)) begin
                            state   <= other_req ? SWITCH : IDLE;
                            sign_on <= 1'b0;
                            gnt_l   <= 1'b0;
                            gnt_r   <= 1'b0;
                        end
                    end else begin
                        step <= step + SW'(1);
                    end
                end
            end else if (state == HOLD) begin
                state <= IDLE;
            end
        end
    end

    assign bus.state    = state;
    assign bus.lr_bar   = lr_bar;
    assign bus.tick     = tick;
    assign bus.sign_on  = sign_on;
    assign bus.sign_clr = sign_clr;
    assign bus.gnt_l    = gnt_l;
    assign bus.gnt_r    = gnt_r;
endmodule

// File: tb/tb_ee201l_detour_ctrl.sv
// Bench for ee201l_detour_ctrl: cycle-count reference model plus directed literal checks.
// Define DETOUR_CTRL_EMERG_EN to include the emergency-hold scenarios.
module tb_ee201l_detour_ctrl;
    localparam int DIV         = 4;
    localparam int SWEEP_STEPS = 4;
    localparam int MIN_SWEEPS  = 2;
    localparam int SPAN        = DIV * SWEEP_STEPS;

    logic clk = 1'b0;
    logic reset_bar;
    int   total = 0;
    int   bad   = 0;

    ee201l_detour_ctrl_if bus ();

    ee201l_detour_ctrl #(
        .DIV(DIV), .SWEEP_STEPS(SWEEP_STEPS), .MIN_SWEEPS(MIN_SWEEPS)
    ) dut (
        .clk(clk),
        .reset_bar(reset_bar),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic em;
`ifdef DETOUR_CTRL_EMERG_EN
    assign em = bus.emerg;
`else
    assign em = 1'b0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state (0..4), cycles elapsed since entering the current run, who held the sign last.
    int m_state  = 0;
    int m_k      = 0;
    bit m_last_l = 1'b0;
    bit m_lr     = 1'b0;
    bit m_clr    = 1'b0;

    task automatic m_enter(input bit l);
        m_state  = l ? 1 : 2;
        m_lr     = l;
        m_last_l = l;
        m_k      = 0;
        m_clr    = 1'b1;
    endtask

    task automatic m_step();
        bit own, other, l;
        if (!reset_bar) begin
            m_state = 0; m_k = 0; m_last_l = 1'b0; m_lr = 1'b0; m_clr = 1'b0;
            return;
        end
        m_clr = 1'b0;
        if (em) begin
            m_clr   = (m_state != 4);
            m_state = 4;
            return;
        end
        case (m_state)
            0: if (bus.req_l || bus.req_r) begin
                if (bus.req_l && bus.req_r) l = !m_last_l;
                else l = bus.req_l;
                m_enter(l);
            end
            1, 2: begin
                own   = (m_state == 1) ? bus.req_l : bus.req_r;
                other = (m_state == 1) ? bus.req_r : bus.req_l;
                if (((m_k + 1) % SPAN == 0) && ((m_k + 1) / SPAN >= MIN_SWEEPS) && (other || !own))
                    m_state = other ? 3 : 0;
                else
                    m_k++;
            end
            3: m_enter(!m_last_l);
            default: m_state = 0;
        endcase
    endtask

    always @(posedge clk) begin
        logic [8:0] exp_v, got_v;
        bit run;
        m_step();
        #1;
        run   = (m_state == 1) || (m_state == 2);
        exp_v = {3'(m_state), m_lr, run && (m_k % DIV == DIV - 1), run, m_clr,
                 m_state == 1, m_state == 2};
        got_v = {bus.state, bus.lr_bar, bus.tick, bus.sign_on, bus.sign_clr, bus.gnt_l, bus.gnt_r};
        chk("cycle_model", 16'(got_v), 16'(exp_v));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.state != 3'd0 && n < limit) begin
            cyc(1);
            n++;
        end
        chk("idle_reached", 16'(bus.state), 16'd0);
    endtask

    // Counts cycles spent in state st (and TICKs seen); at cycle index 'at' drives req_r to 'val'.
    task automatic measure(input logic [2:0] st, input int at, input logic val,
                           output int cycles, output int ticks);
        cycles = 0;
        ticks  = 0;
        while (bus.state == st && cycles < 300) begin
            if (cycles == at) bus.req_r = val;
            cycles++;
            ticks += int'(bus.tick);
            cyc(1);
        end
    endtask

    initial begin
        int cycles, ticks;
        logic [2:0] side;
        reset_bar = 1'b0;
        bus.req_l = 1'b1;
        bus.req_r = 1'b1;
`ifdef DETOUR_CTRL_EMERG_EN
        bus.emerg = 1'b0;
`endif
        cyc(2);
        chk("rst_state", 16'(bus.state), 16'd0);
        chk("rst_outs", 16'({bus.lr_bar, bus.tick, bus.sign_on, bus.sign_clr, bus.gnt_l, bus.gnt_r}), 16'd0);

        // Both held from reset: tie to L, then alternate every two sweeps.
        reset_bar = 1'b1;
        cyc(1);
        chk("first_run_l", 16'({bus.state, bus.lr_bar, bus.sign_clr}), 16'({3'd1, 1'b1, 1'b1}));
        cyc(2);
        chk("no_tick_k2", 16'(bus.tick), 16'd0);
        cyc(1);
        chk("tick_k3", 16'(bus.tick), 16'd1);
        cyc(29);
        chk("switch_after_32", 16'({bus.state, bus.sign_on}), 16'({3'd3, 1'b0}));
        cyc(1);
        chk("run_r_entry", 16'({bus.state, bus.lr_bar, bus.sign_clr}), 16'({3'd2, 1'b0, 1'b1}));
        cyc(33);
        chk("back_to_run_l", 16'({bus.state, bus.lr_bar}), 16'({3'd1, 1'b1}));
        bus.req_l = 1'b0;
        bus.req_r = 1'b0;
        wait_idle(100);

        // One-cycle REQ_L pulse: full two sweeps then idle.
        bus.req_l = 1'b1;
        cyc(1);
        bus.req_l = 1'b0;
        measure(3'd1, -1, 1'b0, cycles, ticks);
        chk("pulse_cycles", 16'(cycles), 16'd32);
        chk("pulse_ticks", 16'(ticks), 16'd8);
        chk("pulse_idle", 16'(bus.state), 16'd0);

        // REQ_R alone, dropped mid third sweep (cycle 40): runs to cycle 47.
        bus.req_r = 1'b1;
        cyc(1);
        measure(3'd2, 40, 1'b0, cycles, ticks);
        chk("r_only_cycles", 16'(cycles), 16'd48);
        chk("r_only_ticks", 16'(ticks), 16'd12);
        chk("r_only_idle", 16'(bus.state), 16'd0);

        // REQ_R raised in the first sweep of RUN_L: switch only after two sweeps.
        bus.req_l = 1'b1;
        cyc(1);
        measure(3'd1, 5, 1'b1, cycles, ticks);
        chk("late_r_cycles", 16'(cycles), 16'd32);
        chk("late_r_switch", 16'(bus.state), 16'd3);
        bus.req_l = 1'b0;
        bus.req_r = 1'b0;
        wait_idle(100);

`ifdef DETOUR_CTRL_EMERG_EN
        bus.req_l = 1'b1;
        bus.req_r = 1'b1;
        cyc(1);
        side = bus.state;
        cyc(6);
        bus.emerg = 1'b1;
        cyc(1);
        chk("hold_entry", 16'({bus.state, bus.tick, bus.sign_clr, bus.sign_on}), 16'({3'd4, 1'b0, 1'b1, 1'b0}));
        cyc(3);
        chk("hold_stay", 16'({bus.state, bus.sign_clr}), 16'({3'd4, 1'b0}));
        bus.emerg = 1'b0;
        cyc(1);
        chk("hold_exit", 16'(bus.state), 16'd0);
        cyc(1);
        chk("hold_rr", 16'(bus.state), 16'((side == 3'd1) ? 3'd2 : 3'd1));
        bus.req_l = 1'b0;
        bus.req_r = 1'b0;
        wait_idle(100);
`endif

        // Random traffic, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) bus.req_l = ~bus.req_l;
            if ($urandom_range(7) == 0) bus.req_r = ~bus.req_r;
`ifdef DETOUR_CTRL_EMERG_EN
            if ($urandom_range(63) == 0) bus.emerg = ~bus.emerg;
`endif
            reset_bar = ($urandom_range(499) != 0);
            cyc(1);
        end
        reset_bar = 1'b1;
        bus.req_l = 1'b0;
        bus.req_r = 1'b0;
`ifdef DETOUR_CTRL_EMERG_EN
        bus.emerg = 1'b0;
`endif
        wait_idle(200);
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
